ped_crossing_ctrl: RTL and testbench
====================================

# ped_crossing_ctrl

Pedestrian crossing controller that sits directly downstream of the traffic-light sequencer. It consumes the sequencer's `red`/`yellow`/`green` lamp outputs and a pedestrian push-button. It grants a timed WALK interval only while traffic is held at pure red, then runs a flashing clearance interval with a visible countdown. Any green seen during WALK or clearance is a safety fault: the block aborts immediately and latches a fault flag.

## Interface
- `WALK_CYCLES`, 8: maximum WALK length in clocks (1..16).
- `FLASH_CYCLES`, 6: clearance length in clocks (1..16).
- `clock`  in  1  single system clock, rising edge.
- `reset`  in  1  asynchronous, active-low reset (0 = reset asserted).
- `red`  in  1  traffic red lamp from the sequencer.
- `yellow`  in  1  traffic yellow lamp from the sequencer.
- `green`  in  1  traffic green lamp from the sequencer.
- `ped_button`  in  1  pedestrian request, level, sampled each clock.
- `walk`  out  1  WALK lamp.
- `dont_walk`  out  1  DON'T WALK lamp; blinks during clearance.
- `countdown`  out  4  cycles remaining in the current timed phase, minus 1.
- `req_pending`  out  1  request latched, not yet served.
- `fault`  out  1  sticky: green observed while pedestrians were released.

## Operation
- Input decode, combinational:
  - `pure_red` = red & ~yellow & ~green.
  - `go` = green | (red & green) | (~red & ~yellow & ~green). Any green, and the illegal all-off combination, are both treated as `go`.
- States: IDLE, ARMED, WALK, FLASH. All outputs are registered, Moore style.
- IDLE:
  - Outputs: dont_walk=1, walk=0, countdown=0.
  - ped_button=1 → ARMED, req_pending=1.
- ARMED:
  - Outputs as IDLE, req_pending=1.
  - pure_red=1 → WALK, load counter with WALK_CYCLES-1, clear req_pending.
- WALK:
  - Outputs: walk=1, dont_walk=0, countdown = counter.
  - Counter decrements every cycle.
  - Exit to FLASH when the counter is 0 or when pure_red drops. The earlier event wins.
  - On entry to FLASH: load counter with FLASH_CYCLES-1 and set the blink bit to 1.
  - ped_button is ignored in WALK.
- FLASH:
  - Outputs: walk=0, dont_walk = blink bit, toggling every cycle starting at 1; countdown = counter.
  - At counter 0: go to ARMED if a request was latched during FLASH, else IDLE.
  - ped_button in FLASH sets req_pending.
- Safety abort:
  - Condition: go=1 while in WALK or FLASH.
  - Action on that edge: go to IDLE, set fault=1, clear req_pending, set countdown=0.
  - fault is cleared only by reset.
  - While fault=1 the block still accepts requests and operates normally. fault is report-only.
- Counter width is 4 bits and never wraps. Decrement is gated at 0.

## Timing
- Reset values: state=IDLE, walk=0, dont_walk=1, countdown=0, req_pending=0, fault=0, blink=0.
- Reset asserts asynchronously. Reset deassertion takes effect at the next rising edge.
- Latency: a button sampled high at edge k gives req_pending=1 after k.
  - If pure_red=1 at edge k+1, walk=1 after k+1.
  - Minimum button-to-walk latency is 2 clocks.
- Full WALK lasts exactly WALK_CYCLES clocks. countdown runs WALK_CYCLES-1 down to 0.
- FLASH lasts exactly FLASH_CYCLES clocks. The dont_walk pattern is 1,0,1,0,...
- Simultaneous events:
  - go=1 and WALK counter=0 on the same edge: the abort wins (IDLE, fault=1).
  - pure_red drops and counter=0 on the same edge: one transition to FLASH.
  - Button and FLASH-end on the same edge: the request is retained, next state is ARMED.
- Reset mid-WALK or mid-FLASH: outputs go to their reset values immediately and the pending request is lost.

## Test plan
- Reset, then ped_button=1 for 1 cycle with pure_red held (red=1, yellow=0, green=0):
  - req_pending=1 for 1 cycle.
  - walk=1 for 8 cycles with countdown 7..0.
  - Then 6 FLASH cycles with dont_walk 1,0,1,0,1,0 and countdown 5..0.
  - Then IDLE, dont_walk=1.
- Request while green=1 for 5 cycles: block stays ARMED (walk=0, req_pending=1). Drive pure red: walk asserts 1 cycle later.
- In WALK at countdown=4, switch lamps to red=1, yellow=1: next cycle is FLASH with countdown=5 and fault=0.
- In FLASH at countdown=3, assert green=1: next cycle is IDLE with walk=0, dont_walk=1, countdown=0, fault=1. fault stays 1 until reset is driven low.
- Press ped_button during FLASH: req_pending=1. After FLASH ends the block is ARMED, and a new WALK starts if pure_red=1.
- Drive reset low asynchronously mid-WALK (between edges): walk=0, dont_walk=1 and countdown=0 immediately, before the next clock edge.

Source files
------------

// File: rtl/ped_crossing_ctrl_if.sv
// Signal bundle between the pedestrian crossing controller and its surroundings:
// traffic lamp inputs, push-button, and the pedestrian lamp/status outputs.
interface ped_crossing_ctrl_if;
    logic       red;
    logic       yellow;
    logic       green;
    logic       ped_button;
    logic       walk;
    logic       dont_walk;
    logic [3:0] countdown;
    logic       req_pending;
    logic       fault;

    modport master (
        output red, yellow, green, ped_button,
        input  walk, dont_walk, countdown, req_pending, fault
    );

    modport slave (
        input  red, yellow, green, ped_button,
        output walk, dont_walk, countdown, req_pending, fault
    );
endinterface

// File: rtl/ped_crossing_ctrl.sv
// Pedestrian crossing controller: grants a timed WALK only under pure red, then a
// flashing clearance with countdown; any green while pedestrians are released aborts.
module ped_crossing_ctrl #(
    parameter int unsigned WALK_CYCLES  = 8,
    parameter int unsigned FLASH_CYCLES = 6
) (
    input  logic              clock,
    input  logic              reset,
    ped_crossing_ctrl_if.slave bus
);

    typedef enum logic [1:0] {StIdle, StArmed, StWalk, StFlash} state_e;

    localparam logic [3:0] WalkLoad  = 4'(WALK_CYCLES - 1);
    localparam logic [3:0] FlashLoad = 4'(FLASH_CYCLES - 1);

    state_e     state_q, state_d;
    logic [3:0] cnt_q, cnt_d;
    logic       blink_q, blink_d;
    logic       req_q, req_d;
    logic       fault_q, fault_d;
    logic       walk_q, walk_d;
    logic       dont_walk_q, dont_walk_d;
    logic [3:0] countdown_q, countdown_d;

    logic pure_red;
    logic go;

    // All-off lamps are treated like green: the sequencer state is unknown.
    assign pure_red = bus.red & ~bus.yellow & ~bus.green;
    assign go       = bus.green | (bus.red & bus.green) | (~bus.red & ~bus.yellow & ~bus.green);

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        blink_d = blink_q;
        req_d   = req_q;
        fault_d = fault_q;

        unique case (state_q)
            StIdle: begin
                if (bus.ped_button) begin
                    state_d = StArmed;
                    req_d   = 1'b1;
                end
            end
            StArmed: begin
                if (pure_red) begin
                    state_d = StWalk;
                    cnt_d   = WalkLoad;
                    req_d   = 1'b0;
                end
            end
            StWalk: begin
                if (go) begin
                    state_d = StIdle;
                    fault_d = 1'b1;
                    req_d   = 1'b0;
                    cnt_d   = 4'd0;
                end else if ((cnt_q == 4'd0) || !pure_red) begin
                    state_d = StFlash;
                    cnt_d   = FlashLoad;
                    blink_d = 1'b1;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            StFlash: begin
                if (go) begin
                    state_d = StIdle;
                    fault_d = 1'b1;
                    req_d   = 1'b0;
                    cnt_d   = 4'd0;
                end else if (cnt_q == 4'd0) begin
                    // A press on the final edge still counts toward the next crossing.
                    req_d   = req_q | bus.ped_button;
                    state_d = (req_q | bus.ped_button) ? StArmed : StIdle;
                end else begin
                    cnt_d   = cnt_q - 4'd1;
                    blink_d = ~blink_q;
                    req_d   = req_q | bus.ped_button;
                end
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    // Outputs are computed from next state so they register alongside it.
    always_comb begin
        walk_d      = (state_d == StWalk);
        dont_walk_d = (state_d == StFlash) ? blink_d : (state_d != StWalk);
        countdown_d = ((state_d == StWalk) || (state_d == StFlash)) ? cnt_d : 4'd0;
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q     <= StIdle;
            cnt_q       <= 4'd0;
            blink_q     <= 1'b0;
            req_q       <= 1'b0;
            fault_q     <= 1'b0;
            walk_q      <= 1'b0;
            dont_walk_q <= 1'b1;
            countdown_q <= 4'd0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            blink_q     <= blink_d;
            req_q       <= req_d;
            fault_q     <= fault_d;
            walk_q      <= walk_d;
            dont_walk_q <= dont_walk_d;
            countdown_q <= countdown_d;
        end
    end

    assign bus.walk        = walk_q;
    assign bus.dont_walk   = dont_walk_q;
    assign bus.countdown   = countdown_q;
    assign bus.req_pending = req_q;
    assign bus.fault       = fault_q;

endmodule

// File: tb/tb_ped_crossing_ctrl.sv
// Directed bench for ped_crossing_ctrl: normal crossing, held request, early exit,
// safety abort, end-of-clearance request and asynchronous reset.
module tb_ped_crossing_ctrl;

    logic clock;
    logic reset;
    int   errors;
    int   checks;

    ped_crossing_ctrl_if bus ();

    ped_crossing_ctrl #(
        .WALK_CYCLES  (8),
        .FLASH_CYCLES (6)
    ) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
        end
    endtask

    task automatic check_outs(input string tag, input logic w, input logic dw,
                              input logic [3:0] cd, input logic rq, input logic ft);
        check({tag, ".walk"},        32'(bus.walk),        32'(w));
        check({tag, ".dont_walk"},   32'(bus.dont_walk),   32'(dw));
        check({tag, ".countdown"},   32'(bus.countdown),   32'(cd));
        check({tag, ".req_pending"}, 32'(bus.req_pending), 32'(rq));
        check({tag, ".fault"},       32'(bus.fault),       32'(ft));
    endtask

    // Sample 1 time unit after the rising edge; inputs change at the same point.
    task automatic step();
        @(posedge clock);
        #1;
    endtask

    initial begin
        errors         = 0;
        checks         = 0;
        reset          = 1'b1;
        bus.red        = 1'b1;
        bus.yellow     = 1'b0;
        bus.green      = 1'b0;
        bus.ped_button = 1'b0;
        #1 reset = 1'b0;
        #1 check_outs("rst_async", 1'b0, 1'b1, 4'd0, 1'b0, 1'b0);
        step();
        step();
        check_outs("rst_held", 1'b0, 1'b1, 4'd0, 1'b0, 1'b0);
        reset = 1'b1;
        step();
        check_outs("idle", 1'b0, 1'b1, 4'd0, 1'b0, 1'b0);

        // Full crossing under pure red
        bus.ped_button = 1'b1;
        step();
        bus.ped_button = 1'b0;
        check_outs("t1_req", 1'b0, 1'b1, 4'd0, 1'b1, 1'b0);
        step();
        for (int i = 0; i < 8; i++) begin
            check_outs("t1_walk", 1'b1, 1'b0, 4'(7 - i), 1'b0, 1'b0);
            step();
        end
        for (int i = 0; i < 6; i++) begin
            check_outs("t1_flash", 1'b0, ((i % 2) == 0), 4'(5 - i), 1'b0, 1'b0);
            step();
        end
        check_outs("t1_idle", 1'b0, 1'b1, 4'd0, 1'b0, 1'b0);

        // Request held off by green
        bus.red        = 1'b0;
        bus.green      = 1'b1;
        bus.ped_button = 1'b1;
        step();
        bus.ped_button = 1'b0;
        for (int i = 0; i < 5; i++) begin
            check_outs("t2_armed", 1'b0, 1'b1, 4'd0, 1'b1, 1'b0);
            step();
        end
        bus.red   = 1'b1;
        bus.green = 1'b0;
        step();
        check_outs("t2_walk", 1'b1, 1'b0, 4'd7, 1'b0, 1'b0);

        // Early exit on red+yellow, then abort on green in clearance
        step();
        step();
        step();
        check_outs("t3_walk4", 1'b1, 1'b0, 4'd4, 1'b0, 1'b0);
        bus.yellow = 1'b1;
        step();
        check_outs("t3_flash", 1'b0, 1'b1, 4'd5, 1'b0, 1'b0);
        bus.yellow = 1'b0;
        step();
        step();
        check_outs("t3_flash3", 1'b0, 1'b1, 4'd3, 1'b0, 1'b0);
        bus.green = 1'b1;
        step();
        check_outs("t3_abort", 1'b0, 1'b1, 4'd0, 1'b0, 1'b1);
        bus.green = 1'b0;

        // Fault is sticky but the block keeps working
        step();
        check_outs("t4_sticky", 1'b0, 1'b1, 4'd0, 1'b0, 1'b1);
        bus.ped_button = 1'b1;
        step();
        bus.ped_button = 1'b0;
        check_outs("t4_req", 1'b0, 1'b1, 4'd0, 1'b1, 1'b1);
        step();
        check_outs("t4_walk", 1'b1, 1'b0, 4'd7, 1'b0, 1'b1);
        repeat (7) step();
        check_outs("t4_walk0", 1'b1, 1'b0, 4'd0, 1'b0, 1'b1);
        bus.yellow = 1'b1;
        step();
        check_outs("t4_drop_at_0", 1'b0, 1'b1, 4'd5, 1'b0, 1'b1);
        bus.yellow = 1'b0;
        repeat (5) step();
        check_outs("t4_flash0", 1'b0, 1'b0, 4'd0, 1'b0, 1'b1);
        bus.ped_button = 1'b1;
        step();
        bus.ped_button = 1'b0;
        check_outs("t4_end_req", 1'b0, 1'b1, 4'd0, 1'b1, 1'b1);
        step();
        check_outs("t4_rewalk", 1'b1, 1'b0, 4'd7, 1'b0, 1'b1);

        // Asynchronous reset between edges mid-WALK
        step();
        step();
        check_outs("t5_walk5", 1'b1, 1'b0, 4'd5, 1'b0, 1'b1);
        #2 reset = 1'b0;
        #1 check_outs("t5_async", 1'b0, 1'b1, 4'd0, 1'b0, 1'b0);
        step();
        reset = 1'b1;
        step();
        check_outs("t5_idle", 1'b0, 1'b1, 4'd0, 1'b0, 1'b0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
